serial_fifo_ctrl: RTL

//  Parametrised successor to the serial (COM) controller. Sits between devctrl and the

---
 rtl/serial_fifo_ctrl_pkg.sv | 38 +++
 rtl/serial_fifo_ctrl_sync_fifo.sv | 69 ++++++
 rtl/serial_fifo_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/serial_fifo_ctrl_pkg.sv
// Shared register-map codes, bit positions and TX FSM states for serial_fifo_ctrl.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
package serial_fifo_ctrl_pkg;

  // Register select codes (addr[3:2])
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_COUNT   = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_READY = 0;
  localparam int ST_RX_AVAIL = 1;
  localparam int ST_RX_OVR   = 2;
  localparam int ST_TX_OVF   = 3;
  localparam int ST_TX_IDLE  = 4;

  // CONTROL bit positions
  localparam int CT_RX_INT_EN  = 0;
  localparam int CT_TX_INT_EN  = 1;
  localparam int CT_RX_FLUSH   = 2;
  localparam int CT_TX_FLUSH   = 3;
  localparam int CT_THRESH_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LAUNCH    = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_e;

  // A threshold of zero would make the RX interrupt permanently asserted; treat it as one.
  function automatic logic [7:0] eff_thresh(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

endpackage

// File: rtl/serial_fifo_ctrl_sync_fifo.sv
// Synchronous FIFO with push/pop/flush, occupancy count and combinational head.
// Latency: push visible at head/count one edge later; head is combinational from read pointer.
// Backpressure: push on full accepted only when a real pop happens the same edge; pop on empty ignored; flush wins.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push_i, data_i    write request and data
//   pop_i             read request (head_o is the value being popped)
//   flush_i           empty the FIFO this edge, discarding concurrent push/pop
//   head_o            oldest entry (undefined while empty)
//   count_o           occupancy, 0..DEPTH
//   full_o, empty_o   status
module serial_fifo_ctrl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // A pop frees a slot this edge, so a push onto a full FIFO can still land.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
      else if (!push_ok && pop_ok) count_q <= count_q - CW'(1);
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/serial_fifo_ctrl.sv
// Serial (COM) controller: CPU register map over RX/TX FIFOs, sticky errors, RX threshold interrupt, TX launch FSM.
// Latency: register reads combinational; side effects at edge; int_o registered (1 cycle); launch 1 cycle after TX data present.
// Backpressure: RX full drops bytes (rxOvr), TX full drops CPU writes (txOvf); FSM waits for txdBusy_i low before launching.
//
// Ports:
//   clk, rst                               clock (clk25), asynchronous active-high reset
//   enable_i, readEnable_i, regSel_i       CPU access strobe, direction, register select
//   dataSave_i / dataLoad_o                CPU write data / read data (combinational)
//   int_o                                  registered interrupt request
//   rxdReady_i, rxdData_i                  byte from async_receiver
//   txdBusy_i, txdStart_o, txdData_o       handshake and byte to async_transmitter
module serial_fifo_ctrl #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic [1:0]  regSel_i,
  input  logic [31:0] dataSave_i,
  output logic [31:0] dataLoad_o,
  output logic        int_o,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o
);

  import serial_fifo_ctrl_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd_acc, wr_acc;
  logic             data_rd, data_wr, status_wr, control_wr;
  logic             rx_flush, tx_flush;
  logic [7:0]       rx_head, tx_head;
  logic [CNT_W-1:0] rx_count, tx_count;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic             tx_launch, tx_idle;
  logic             rx_ovr_set, tx_ovf_set;
  logic             int_d;
  logic             unused_hi;

  logic             rx_int_en_q, tx_int_en_q;
  logic [7:0]       rx_thresh_q;
  logic             rx_ovr_q, tx_ovf_q;
  logic             int_q;
  tx_state_e        state_q;
  logic             txd_start_q;
  logic [7:0]       txd_data_q;

  assign unused_hi = ^dataSave_i[31:16];

  assign rd_acc     = enable_i & readEnable_i;
  assign wr_acc     = enable_i & ~readEnable_i;
  assign data_rd    = rd_acc & (regSel_i == REG_DATA);
  assign data_wr    = wr_acc & (regSel_i == REG_DATA);
  assign status_wr  = wr_acc & (regSel_i == REG_STATUS);
  assign control_wr = wr_acc & (regSel_i == REG_CONTROL);
  assign rx_flush   = control_wr & dataSave_i[CT_RX_FLUSH];
  assign tx_flush   = control_wr & dataSave_i[CT_TX_FLUSH];

  serial_fifo_ctrl_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rxdReady_i),
    .data_i  (rxdData_i),
    .pop_i   (data_rd),
    .flush_i (rx_flush),
    .head_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  serial_fifo_ctrl_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (data_wr),
    .data_i  (dataSave_i[7:0]),
    .pop_i   (tx_launch),
    .flush_i (tx_flush),
    .head_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // No launch on a flush edge: the popped byte would belong to a FIFO being emptied.
  assign tx_launch = (state_q == TX_IDLE) & ~tx_empty & ~txdBusy_i & ~tx_flush;
  assign tx_idle   = tx_empty & (state_q == TX_IDLE) & ~txdBusy_i;

  // Full implies non-empty, so a DATA read on a full RX FIFO always frees the slot.
  assign rx_ovr_set = rxdReady_i & rx_full & ~data_rd & ~rx_flush;
  assign tx_ovf_set = data_wr & tx_full & ~tx_launch;

  assign int_d = (rx_int_en_q & (32'(rx_count) >= 32'(eff_thresh(rx_thresh_q))))
               | (tx_int_en_q & tx_idle)
               | rx_ovr_q;

  // Control register, sticky flags (set beats W1C on the same edge), interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_int_en_q <= 1'b1;
      tx_int_en_q <= 1'b0;
      rx_thresh_q <= 8'd1;
      rx_ovr_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      if (control_wr) begin
        rx_int_en_q <= dataSave_i[CT_RX_INT_EN];
        tx_int_en_q <= dataSave_i[CT_TX_INT_EN];
        rx_thresh_q <= dataSave_i[CT_THRESH_LSB +: 8];
      end
      if (rx_ovr_set)                                rx_ovr_q <= 1'b1;
      else if (status_wr && dataSave_i[ST_RX_OVR])   rx_ovr_q <= 1'b0;
      if (tx_ovf_set)                                tx_ovf_q <= 1'b1;
      else if (status_wr && dataSave_i[ST_TX_OVF])   tx_ovf_q <= 1'b0;
      int_q <= int_d;
    end
  end

  // TX launch FSM: the start pulse is the LAUNCH state itself, so one pulse per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      txd_start_q <= 1'b0;
      txd_data_q  <= 8'h00;
    end else begin
      txd_start_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (tx_launch) begin
            state_q     <= TX_LAUNCH;
            txd_start_q <= 1'b1;
            txd_data_q  <= tx_head;
          end
        end
        TX_LAUNCH:    state_q <= TX_WAIT_BUSY;
        TX_WAIT_BUSY: if (txdBusy_i)  state_q <= TX_WAIT_DONE;
        TX_WAIT_DONE: if (!txdBusy_i) state_q <= TX_IDLE;
        default:      state_q <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    dataLoad_o = '0;
    case (regSel_i)
      REG_DATA: begin
        if (!rx_empty) dataLoad_o[7:0] = rx_head;
      end
      REG_STATUS: begin
        dataLoad_o[ST_TX_READY] = ~tx_full;
        dataLoad_o[ST_RX_AVAIL] = ~rx_empty;
        dataLoad_o[ST_RX_OVR]   = rx_ovr_q;
        dataLoad_o[ST_TX_OVF]   = tx_ovf_q;
        dataLoad_o[ST_TX_IDLE]  = tx_idle;
      end
      REG_CONTROL: begin
        dataLoad_o[CT_RX_INT_EN]            = rx_int_en_q;
        dataLoad_o[CT_TX_INT_EN]            = tx_int_en_q;
        dataLoad_o[CT_THRESH_LSB +: 8]      = rx_thresh_q;
      end
      REG_COUNT: begin
        dataLoad_o[CNT_W-1:0]   = tx_count;
        dataLoad_o[16 +: CNT_W] = rx_count;
      end
      default: dataLoad_o = '0;
    endcase
  end

  assign int_o      = int_q;
  assign txdStart_o = txd_start_q;
  assign txdData_o  = txd_data_q;

endmodule
